// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for one port of the RAM arbiter.
// master = requester (CPU or DMA), slave = arbiter.
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU
// load/store path and the RS232 loader DMA; read data returned in grant order.
module ram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetN,
  ram_arbiter_if.slave  cpu,
  ram_arbiter_if.slave  dma,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic          last_gnt;
  logic          cpu_gnt, dma_gnt;
  logic          tag1_v, tag1_own;
  logic          tag2_v, tag2_own;
  logic          cpu_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    cpu_gnt = resetN && cpu.req && (!dma.req || (last_gnt == OWN_DMA));
    dma_gnt = resetN && dma.req && (!cpu.req || (last_gnt == OWN_CPU));
  end

  assign cpu.gnt    = cpu_gnt;
  assign dma.gnt    = dma_gnt;
  assign cpu.rvalid = cpu_rvalid_q;
  assign dma.rvalid = dma_rvalid_q;
  assign cpu.rdata  = cpu_rdata_q;
  assign dma.rdata  = dma_rdata_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_gnt     <= OWN_DMA;
      ram_addr     <= '0;
      ram_data     <= '0;
      ram_rden     <= 1'b0;
      ram_wren     <= 1'b0;
      tag1_v       <= 1'b0;
      tag1_own     <= OWN_CPU;
      tag2_v       <= 1'b0;
      tag2_own     <= OWN_CPU;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      tag1_v   <= 1'b0;
      if (cpu_gnt) begin
        ram_addr <= cpu.addr;
        ram_data <= cpu.wdata;
        ram_wren <= cpu.we;
        ram_rden <= !cpu.we;
        tag1_v   <= !cpu.we;
        tag1_own <= OWN_CPU;
        last_gnt <= OWN_CPU;
      end else if (dma_gnt) begin
        ram_addr <= dma.addr;
        ram_data <= dma.wdata;
        ram_wren <= dma.we;
        ram_rden <= !dma.we;
        tag1_v   <= !dma.we;
        tag1_own <= OWN_DMA;
        last_gnt <= OWN_DMA;
      end

      // Stage 2 lines up with ram_q; its owner takes the data on this edge.
      tag2_v       <= tag1_v;
      tag2_own     <= tag1_own;
      cpu_rvalid_q <= tag2_v && (tag2_own == OWN_CPU);
      dma_rvalid_q <= tag2_v && (tag2_own == OWN_DMA);
      if (tag2_v && (tag2_own == OWN_CPU)) cpu_rdata_q <= ram_q;
      if (tag2_v && (tag2_own == OWN_DMA)) dma_rdata_q <= ram_q;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural 1-cycle RAM.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_rden, ram_wren;
  logic [31:0] ram_q = '0;
  logic [31:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter_if #(.AW(16), .DW(32)) cpu_if ();
  ram_arbiter_if #(.AW(16), .DW(32)) dma_if ();

  ram_arbiter #(.AW(16), .DW(32)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .cpu     (cpu_if),
    .dma     (dma_if),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_rden(ram_rden),
    .ram_wren(ram_wren),
    .ram_q   (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr[9:0]] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr[9:0]];
  end

  typedef struct {
    logic        creq, cwe;
    logic [15:0] caddr;
    logic        dreq, dwe;
    logic [15:0] daddr;
    logic [31:0] dwdata;
    logic        e_cgnt, e_dgnt, e_rden, e_wren;
    logic [15:0] e_addr;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic creq, cwe, input logic [15:0] caddr,
                     input logic dreq, dwe, input logic [15:0] daddr, input logic [31:0] dwdata,
                     input logic gc, gd, rd, wr, input logic [15:0] a,
                     input logic crv, input logic [31:0] crd, input logic drv, input logic [31:0] drd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.e_cgnt = gc; v.e_dgnt = gd; v.e_rden = rd; v.e_wren = wr; v.e_addr = a;
    v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int tag);
    n_vec++;
    chk("rst_cpu_gnt", tag, {31'd0, cpu_if.gnt}, 32'd0);
    chk("rst_dma_gnt", tag, {31'd0, dma_if.gnt}, 32'd0);
    chk("rst_ram_addr", tag, {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_data", tag, ram_data, 32'd0);
    chk("rst_ram_rden", tag, {31'd0, ram_rden}, 32'd0);
    chk("rst_ram_wren", tag, {31'd0, ram_wren}, 32'd0);
    chk("rst_cpu_rvalid", tag, {31'd0, cpu_if.rvalid}, 32'd0);
    chk("rst_dma_rvalid", tag, {31'd0, dma_if.rvalid}, 32'd0);
    chk("rst_cpu_rdata", tag, cpu_if.rdata, 32'd0);
    chk("rst_dma_rdata", tag, dma_if.rdata, 32'd0);
  endtask

  task automatic drive(input logic creq, cwe, input logic [15:0] caddr,
                       input logic dreq, dwe, input logic [15:0] daddr, input logic [31:0] dwdata);
    cpu_if.req = creq; cpu_if.we = cwe; cpu_if.addr = caddr; cpu_if.wdata = 32'h0;
    dma_if.req = dreq; dma_if.we = dwe; dma_if.addr = daddr; dma_if.wdata = dwdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'hDEAD_BEEF;

    //   C: req we addr   D: req we addr wdata    | gc gd rd wr addr | crv crd | drv drd
    add(1,0,16'h0001, 1,0,16'h0002,0,  1,0,0,0,16'h0000, 0,32'h0,        0,32'h0);
    add(1,0,16'h0001, 1,0,16'h0002,0,  0,1,1,0,16'h0001, 0,32'h0,        0,32'h0);
    add(1,0,16'h0001, 1,0,16'h0002,0,  1,0,1,0,16'h0002, 0,32'h0,        0,32'h0);
    add(1,0,16'h0001, 1,0,16'h0002,0,  0,1,1,0,16'h0001, 1,32'h10000001, 0,32'h0);
    add(1,0,16'h0001, 1,0,16'h0002,0,  1,0,1,0,16'h0002, 0,32'h10000001, 1,32'h10000002);
    add(1,0,16'h0001, 1,0,16'h0002,0,  0,1,1,0,16'h0001, 1,32'h10000001, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,1,0,16'h0002, 0,32'h10000001, 1,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0002, 1,32'h10000001, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0002, 0,32'h10000001, 1,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0002, 0,32'h10000001, 0,32'h10000002);
    // single CPU read
    add(1,0,16'h0010, 0,0,16'h0000,0,  1,0,0,0,16'h0002, 0,32'h10000001, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,1,0,16'h0010, 0,32'h10000001, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0010, 0,32'h10000001, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0010, 1,32'hDEADBEEF, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0010, 0,32'hDEADBEEF, 0,32'h10000002);
    // DMA write then CPU read of the same word
    add(0,0,16'h0000, 1,1,16'h0100,32'hA5, 0,1,0,0,16'h0010, 0,32'hDEADBEEF, 0,32'h10000002);
    add(1,0,16'h0100, 0,0,16'h0000,0,  1,0,0,1,16'h0100, 0,32'hDEADBEEF, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,1,0,16'h0100, 0,32'hDEADBEEF, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0100, 0,32'hDEADBEEF, 0,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0100, 1,32'h000000A5, 0,32'h10000002);
    // DMA back-to-back reads
    add(0,0,16'h0000, 1,0,16'h0000,0,  0,1,0,0,16'h0100, 0,32'h000000A5, 0,32'h10000002);
    add(0,0,16'h0000, 1,0,16'h0001,0,  0,1,1,0,16'h0000, 0,32'h000000A5, 0,32'h10000002);
    add(0,0,16'h0000, 1,0,16'h0002,0,  0,1,1,0,16'h0001, 0,32'h000000A5, 0,32'h10000002);
    add(0,0,16'h0000, 1,0,16'h0003,0,  0,1,1,0,16'h0002, 0,32'h000000A5, 1,32'h10000000);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,1,0,16'h0003, 0,32'h000000A5, 1,32'h10000001);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0003, 0,32'h000000A5, 1,32'h10000002);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0003, 0,32'h000000A5, 1,32'h10000003);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0003, 0,32'h000000A5, 0,32'h10000003);
    // tie after a DMA grant: CPU first, then the held DMA request
    add(1,0,16'h0004, 1,0,16'h0005,0,  1,0,0,0,16'h0003, 0,32'h000000A5, 0,32'h10000003);
    add(0,0,16'h0000, 1,0,16'h0005,0,  0,1,1,0,16'h0004, 0,32'h000000A5, 0,32'h10000003);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,1,0,16'h0005, 0,32'h000000A5, 0,32'h10000003);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0005, 1,32'h10000004, 0,32'h10000003);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0005, 0,32'h10000004, 1,32'h10000005);
    add(0,0,16'h0000, 0,0,16'h0000,0,  0,0,0,0,16'h0005, 0,32'h10000004, 0,32'h10000005);

    // reset held with both ports requesting
    drive(1,0,16'h0001, 1,0,16'h0002,0);
    repeat (3) @(negedge clk);
    chk_all_zero(-1);
    @(posedge clk);
    #2 resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
      #1;
      n_vec++;
      chk("cpu_gnt",    i, {31'd0, cpu_if.gnt},    {31'd0, vecs[i].e_cgnt});
      chk("dma_gnt",    i, {31'd0, dma_if.gnt},    {31'd0, vecs[i].e_dgnt});
      chk("ram_rden",   i, {31'd0, ram_rden},      {31'd0, vecs[i].e_rden});
      chk("ram_wren",   i, {31'd0, ram_wren},      {31'd0, vecs[i].e_wren});
      chk("ram_addr",   i, {16'd0, ram_addr},      {16'd0, vecs[i].e_addr});
      chk("cpu_rvalid", i, {31'd0, cpu_if.rvalid}, {31'd0, vecs[i].e_crv});
      chk("dma_rvalid", i, {31'd0, dma_if.rvalid}, {31'd0, vecs[i].e_drv});
      chk("cpu_rdata",  i, cpu_if.rdata,           vecs[i].e_crd);
      chk("dma_rdata",  i, dma_if.rdata,           vecs[i].e_drd);
      if (i == 16) chk("ram_data_wr", i, ram_data, 32'h0000_00A5);
    end

    // reset one cycle after a CPU read grant: that read must never return
    @(negedge clk);
    drive(1,0,16'h0007, 0,0,16'h0000,0);
    #1;
    n_vec++;
    chk("mid_cpu_gnt", 100, {31'd0, cpu_if.gnt}, 32'd1);
    @(negedge clk);
    drive(1,0,16'h0008, 1,0,16'h0009,0);
    resetN = 1'b0;
    #1;
    chk_all_zero(101);
    @(negedge clk);
    #1;
    chk_all_zero(102);

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) resetN = 1'b1;
      if (k == 1) cpu_if.req = 1'b0;
      if (k == 2) dma_if.req = 1'b0;
      #1;
      n_vec++;
      chk("post_cpu_gnt",    200 + k, {31'd0, cpu_if.gnt},    {31'd0, k == 0});
      chk("post_dma_gnt",    200 + k, {31'd0, dma_if.gnt},    {31'd0, k == 1});
      chk("post_cpu_rvalid", 200 + k, {31'd0, cpu_if.rvalid}, {31'd0, k == 3});
      chk("post_dma_rvalid", 200 + k, {31'd0, dma_if.rvalid}, {31'd0, k == 4});
      if (k == 3) chk("post_cpu_rdata", 200 + k, cpu_if.rdata, 32'h1000_0008);
      if (k == 4) chk("post_dma_rdata", 200 + k, dma_if.rdata, 32'h1000_0009);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
